mdp_packet_rx: RTL and testbench

- Parametrised successor to the fixed 18-byte market-data packet receiver.
- Consumes a byte stream framed as SYNC + PAYLOAD_BYTES payload + 1 XOR checksum, and validates the checksum.
- Buffers good packets in a small FIFO and presents them on a valid/ready interface to the downstream order/strategy logic.
- Adds inter-byte timeout recovery and overflow/error signalling.

---
 rtl/hft_pkg.sv | 19 +
 rtl/mdp_pkt_fifo.sv | 53 +++++
 rtl/mdp_packet_rx.sv | 127 ++++++++++++
 tb/tb_mdp_packet_rx.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hft_pkg.sv
// rtl/hft_pkg.sv - shared types and defaults for the market-data packet receiver
package hft_pkg;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    PAYLOAD = 2'd1,
    CHECK   = 2'd2
  } rx_state_e;

  localparam logic [7:0] MDP_SYNC_DEFAULT    = 8'hAA;
  localparam int         MDP_PAYLOAD_DEFAULT = 16;
  localparam int         MDP_STATS_W         = 16;

  // Saturating increment for the statistics counters.
  function automatic logic [MDP_STATS_W-1:0] sat_inc(input logic [MDP_STATS_W-1:0] v);
    return (&v) ? v : v + MDP_STATS_W'(1);
  endfunction

endpackage

// File: rtl/mdp_pkt_fifo.sv
// rtl/mdp_pkt_fifo.sv - first-word-fall-through packet FIFO; push succeeds when full if popped the same cycle
module mdp_pkt_fifo #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] data_in,
  input  logic             pop,
  output logic [WIDTH-1:0] data_out,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  // Empty reads as zero so the head is clean out of reset and after draining.
  assign data_out = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= data_in;
  end

endmodule

// File: rtl/mdp_packet_rx.sv
// rtl/mdp_packet_rx.sv - framed market-data receiver with XOR check, timeout and packet FIFO; stats via MDP_PACKET_RX_STATS_EN
module mdp_packet_rx
  import hft_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE     = MDP_SYNC_DEFAULT,
  parameter int         PAYLOAD_BYTES = MDP_PAYLOAD_DEFAULT,
  parameter int         TIMEOUT_CYC   = 1024,
  parameter int         FIFO_DEPTH    = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [7:0]                 rx_byte,
  input  logic                       rx_valid,
  output logic [PAYLOAD_BYTES*8-1:0] pkt_data,
  output logic                       pkt_valid,
  input  logic                       pkt_ready,
  output logic                       crc_err,
  output logic                       overflow,
  output logic                       timeout,
`ifdef MDP_PACKET_RX_STATS_EN
  output logic [MDP_STATS_W-1:0]     good_cnt,
  output logic [MDP_STATS_W-1:0]     crc_cnt,
  output logic [MDP_STATS_W-1:0]     drop_cnt,
`endif
  output logic                       busy
);

  localparam int PLW   = PAYLOAD_BYTES * 8;
  localparam int IDX_W = (PAYLOAD_BYTES > 1) ? $clog2(PAYLOAD_BYTES) : 1;
  localparam int TW    = $clog2(TIMEOUT_CYC + 1);

  rx_state_e        state;
  logic [IDX_W-1:0] idx;
  logic [7:0]       acc;
  logic [TW-1:0]    timer;
  logic [PLW-1:0]   payload;

  logic fifo_full;
  logic fifo_empty;
  logic pop;
  logic ck_ok;
  logic push;

  assign pkt_valid = !fifo_empty;
  assign pop       = pkt_valid && pkt_ready;
  assign busy      = (state != HUNT);
  assign ck_ok     = (state == CHECK) && rx_valid && (rx_byte == acc);
  assign push      = ck_ok && (!fifo_full || pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= HUNT;
      idx      <= '0;
      acc      <= '0;
      timer    <= '0;
      payload  <= '0;
      crc_err  <= 1'b0;
      overflow <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      crc_err  <= 1'b0;
      overflow <= 1'b0;
      timeout  <= 1'b0;
      case (state)
        HUNT: begin
          if (rx_valid && rx_byte == SYNC_BYTE) begin
            state <= PAYLOAD;
            idx   <= '0;
            acc   <= '0;
            timer <= '0;
          end
        end
        PAYLOAD, CHECK: begin
          // An arriving byte always beats the timeout on the same cycle.
          if (rx_valid) begin
            timer <= '0;
            if (state == PAYLOAD) begin
              payload <= (payload << 8) | PLW'(rx_byte);
              acc     <= acc ^ rx_byte;
              if (idx == IDX_W'(PAYLOAD_BYTES - 1)) state <= CHECK;
              else                                   idx   <= idx + IDX_W'(1);
            end else begin
              state <= HUNT;
              if (rx_byte != acc) crc_err  <= 1'b1;
              else if (!push)     overflow <= 1'b1;
            end
          end else if (timer == TW'(TIMEOUT_CYC - 1)) begin
            state   <= HUNT;
            timeout <= 1'b1;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        default: state <= HUNT;
      endcase
    end
  end

  mdp_pkt_fifo #(
    .WIDTH (PLW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .data_in  (payload),
    .pop      (pop),
    .data_out (pkt_data),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

`ifdef MDP_PACKET_RX_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      good_cnt <= '0;
      crc_cnt  <= '0;
      drop_cnt <= '0;
    end else begin
      if (push)                 good_cnt <= sat_inc(good_cnt);
      if (crc_err)              crc_cnt  <= sat_inc(crc_cnt);
      if (overflow || timeout)  drop_cnt <= sat_inc(drop_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_mdp_packet_rx.sv
// tb/tb_mdp_packet_rx.sv - directed scoreboard bench for mdp_packet_rx
module tb_mdp_packet_rx;

  localparam int PB  = 16;
  localparam int PW  = PB * 8;
  localparam int TO  = 64;
  localparam int DEP = 4;
  localparam logic [PW-1:0] P1 = 128'h4141504c696871ba006b69006a400000;
  localparam logic [PW-1:0] P3 = 128'h4141504c69aa71ba006b69006a400000;

  logic          clk;
  logic          rst_n;
  logic [7:0]    rx_byte;
  logic          rx_valid;
  logic [PW-1:0] pkt_data;
  logic          pkt_valid;
  logic          pkt_ready;
  logic          crc_err;
  logic          overflow;
  logic          timeout;
  logic          busy;
`ifdef MDP_PACKET_RX_STATS_EN
  logic [15:0]   good_cnt;
  logic [15:0]   crc_cnt;
  logic [15:0]   drop_cnt;
`endif

  mdp_packet_rx #(
    .SYNC_BYTE     (8'hAA),
    .PAYLOAD_BYTES (PB),
    .TIMEOUT_CYC   (TO),
    .FIFO_DEPTH    (DEP)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_byte   (rx_byte),
    .rx_valid  (rx_valid),
    .pkt_data  (pkt_data),
    .pkt_valid (pkt_valid),
    .pkt_ready (pkt_ready),
    .crc_err   (crc_err),
    .overflow  (overflow),
    .timeout   (timeout),
`ifdef MDP_PACKET_RX_STATS_EN
    .good_cnt  (good_cnt),
    .crc_cnt   (crc_cnt),
    .drop_cnt  (drop_cnt),
`endif
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [PW-1:0] sb [$];
  int n_crc = 0, n_ovf = 0, n_to = 0, n_pop = 0;
  int exp_crc = 0, exp_ovf = 0, exp_to = 0;

  task automatic chk(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] xsum(input logic [PW-1:0] p);
    logic [7:0] x = 8'h00;
    for (int i = 0; i < PB; i++) x ^= p[i*8 +: 8];
    return x;
  endfunction

  function automatic logic [PW-1:0] with_b7(input logic [7:0] v);
    logic [PW-1:0] p = P1;
    p[PW-1-8*7 -: 8] = v;
    return p;
  endfunction

  // Pulses are counted by cycle, so a stretched pulse also shows up as a count error.
  always @(posedge clk) begin
    if (rst_n) begin
      if (crc_err)  n_crc++;
      if (overflow) n_ovf++;
      if (timeout)  n_to++;
      if (pkt_valid && pkt_ready) begin
        logic [PW-1:0] e;
        e = (sb.size() > 0) ? sb.pop_front() : 'x;
        chk("pop_data", pkt_data, e);
        n_pop++;
      end
    end
  end

  task automatic drive(input logic [7:0] b);
    @(negedge clk);
    rx_byte  = b;
    rx_valid = 1'b1;
  endtask

  task automatic send_frame(input logic [PW-1:0] p, input logic corrupt, input logic ready_on_ck);
    logic [7:0] ck;
    logic       acc;
    ck = xsum(p) ^ (corrupt ? 8'h01 : 8'h00);
    drive(8'hAA);
    for (int i = 0; i < PB; i++) drive(p[PW-1-8*i -: 8]);
    @(negedge clk);
    rx_byte  = ck;
    rx_valid = 1'b1;
    if (ready_on_ck) pkt_ready = 1'b1;
    acc = !corrupt && (sb.size() < DEP || (pkt_ready && sb.size() > 0));
    if (acc)           sb.push_back(p);
    else if (!corrupt) exp_ovf++;
    if (corrupt)       exp_crc++;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  initial begin
    int k;
    int pops0;
    rst_n     = 1'b0;
    rx_valid  = 1'b0;
    rx_byte   = 8'h00;
    pkt_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_pkt_valid", pkt_valid, 0);
    chk("rst_pkt_data",  pkt_data,  0);
    chk("rst_busy",      busy,      0);
    chk("rst_crc_err",   crc_err,   0);
    chk("rst_overflow",  overflow,  0);
    chk("rst_timeout",   timeout,   0);
    rst_n = 1'b1;

    // good frame
    send_frame(P1, 1'b0, 1'b0);
    chk("good_valid",   pkt_valid, 1);
    chk("good_data",    pkt_data,  P1);
    chk("good_crc_err", crc_err,   0);
    chk("good_ovf",     overflow,  0);
    chk("good_busy",    busy,      0);
    @(negedge clk);
    chk("good_popped",  pkt_valid, 0);

    // bad checksum, then recovery
    send_frame(P1, 1'b1, 1'b0);
    chk("bad_crc_err", crc_err,   1);
    chk("bad_valid",   pkt_valid, 0);
    @(negedge clk);
    chk("bad_crc_pulse_end", crc_err, 0);
    send_frame(with_b7(8'hBB), 1'b0, 1'b0);
    chk("recover_valid", pkt_valid, 1);
    chk("recover_data",  pkt_data,  with_b7(8'hBB));
    @(negedge clk);

    // garbage before sync, sync value inside payload
    drive(8'h00); drive(8'h13); drive(8'h55);
    @(negedge clk);
    rx_valid = 1'b0;
    chk("garbage_busy", busy, 0);
    send_frame(P3, 1'b0, 1'b0);
    chk("aa_payload_valid", pkt_valid, 1);
    chk("aa_payload_data",  pkt_data,  P3);
    @(negedge clk);

    // inter-byte timeout
    drive(8'hAA);
    for (int i = 0; i < 5; i++) drive(P1[PW-1-8*i -: 8]);
    @(negedge clk);
    rx_valid = 1'b0;
    chk("to_busy_before", busy, 1);
    k = 0;
    while (k < 200) begin
      @(negedge clk);
      k++;
      if (timeout) break;
    end
    exp_to++;
    chk("to_cycle", k, TO);
    chk("to_busy_after", busy, 0);
    @(negedge clk);
    chk("to_pulse_end", timeout, 0);
    send_frame(P1, 1'b0, 1'b0);
    chk("after_to_data", pkt_data, P1);
    @(negedge clk);

    // backpressure, overflow, push+pop at full
    pkt_ready = 1'b0;
    send_frame(with_b7(8'hBA), 1'b0, 1'b0);
    send_frame(with_b7(8'hBB), 1'b0, 1'b0);
    send_frame(with_b7(8'hBD), 1'b0, 1'b0);
    send_frame(with_b7(8'hBE), 1'b0, 1'b0);
    chk("full_no_ovf", overflow, 0);
    send_frame(with_b7(8'hC0), 1'b0, 1'b0);
    chk("ovf_pulse",     overflow, 1);
    chk("ovf_head_data", pkt_data, with_b7(8'hBA));
    chk("ovf_sb_depth",  sb.size(), DEP);
    pops0 = n_pop;
    send_frame(with_b7(8'hC1), 1'b0, 1'b1);
    chk("pushpop_no_ovf", overflow,  0);
    chk("pushpop_valid",  pkt_valid, 1);
    chk("pushpop_head",   pkt_data,  with_b7(8'hBB));
    k = 0;
    while (pkt_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("drain_sb_empty", sb.size(), 0);
    chk("drain_pops",     n_pop - pops0, 5);

    // async reset mid-frame with queued packets
    pkt_ready = 1'b0;
    send_frame(P1, 1'b0, 1'b0);
    send_frame(P3, 1'b0, 1'b0);
    drive(8'hAA); drive(8'h41); drive(8'h41);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_pkt_valid", pkt_valid, 0);
    chk("arst_busy",      busy,      0);
    chk("arst_pkt_data",  pkt_data,  0);
    sb.delete();
    rx_valid = 1'b0;
    @(negedge clk);
    chk("arst_no_crc", crc_err, 0);
    @(negedge clk);
    rst_n = 1'b1;
`ifdef MDP_PACKET_RX_STATS_EN
    chk("stats_good_rst", good_cnt, 0);
    chk("stats_crc_rst",  crc_cnt,  0);
    chk("stats_drop_rst", drop_cnt, 0);
`endif
    pkt_ready = 1'b1;
    send_frame(P3, 1'b0, 1'b0);
    chk("post_rst_valid", pkt_valid, 1);
    chk("post_rst_data",  pkt_data,  P3);
    @(negedge clk);
`ifdef MDP_PACKET_RX_STATS_EN
    chk("stats_good_one", good_cnt, 1);
`endif

    chk("crc_pulse_count", n_crc, exp_crc);
    chk("ovf_pulse_count", n_ovf, exp_ovf);
    chk("to_pulse_count",  n_to,  exp_to);
    chk("final_sb_empty",  sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

endmodule
